// File: rtl/bet_sequencer.sv
// bet_sequencer
// Initiator side of the lottery bet-checking interface. Collects a 4-number
// bet over a valid/ready handshake and rejects it if any two numbers are
// equal. A good bet is driven onto B1..B4, then stepped through the checker
// with a number/Set strobe for each index. Completed bets are counted.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid, in_num     entry source beat (5-bit number)
//   in_ready             block accepts a beat this cycle (COLLECT only)
//   cancel               discards a partially entered bet (COLLECT only)
//   B1..B4               bet numbers driven to the checker
//   Set, number          checker strobe and index of the number being checked
//   RD_ERR               bet rejected because of duplicate numbers
//   busy                 high in CHECK, DRIVE and ERROR
//   done                 one-cycle pulse when a bet completes
//   bet_count            completed bets, saturating at 1023
module bet_sequencer #(
    parameter int SET_GAP  = 1,
    parameter int ERR_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [4:0] in_num,
    output logic       in_ready,
    input  logic       cancel,
    output logic [4:0] B1,
    output logic [4:0] B2,
    output logic [4:0] B3,
    output logic [4:0] B4,
    output logic       Set,
    output logic [1:0] number,
    output logic       RD_ERR,
    output logic       busy,
    output logic       done,
    output logic [9:0] bet_count
);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_CHECK   = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_ASSERT = 2'd1,
        PH_GAP    = 2'd2
    } phase_t;

    // Terminal values of the shared cycle counter for GAP and ERROR.
    localparam logic [3:0] GAP_LAST = 4'(SET_GAP - 1);
    localparam logic [3:0] ERR_LAST = 4'(ERR_HOLD - 1);

    state_t     state_r, state_s;
    phase_t     phase_r, phase_s;
    logic [1:0] idx_r, idx_s;
    logic [3:0] cnt_r, cnt_s;
    logic [1:0] k_r;
    logic [4:0] slot_r [4];

    // True when any of the six number pairs match.
    function automatic logic has_dup(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] c, input logic [4:0] d);
        return (a == b) || (a == c) || (a == d) ||
               (b == c) || (b == d) || (c == d);
    endfunction

    // Next-state logic for the sequencer FSM and its DRIVE sub-phases.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_COLLECT: begin
                // cancel wins over the accept of a 4th beat
                if (!cancel && in_valid && (k_r == 2'd3)) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_CHECK: begin
                cnt_s = 4'd0;
                if (has_dup(slot_r[0], slot_r[1], slot_r[2], slot_r[3])) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_DRIVE;
                    phase_s = PH_SETUP;
                    idx_s   = 2'd0;
                end
            end
            ST_DRIVE: begin
                case (phase_r)
                    PH_SETUP:  phase_s = PH_ASSERT;
                    PH_ASSERT: begin
                        phase_s = PH_GAP;
                        cnt_s   = 4'd0;
                    end
                    PH_GAP: begin
                        if (cnt_r == GAP_LAST) begin
                            phase_s = PH_SETUP;
                            if (idx_r == 2'd3) begin
                                state_s = ST_DONE;
                            end else begin
                                idx_s = idx_r + 2'd1;
                            end
                        end else begin
                            cnt_s = cnt_r + 4'd1;
                        end
                    end
                    default:   phase_s = PH_SETUP;
                endcase
            end
            ST_DONE:  state_s = ST_COLLECT;
            ST_ERROR: begin
                if (cnt_r == ERR_LAST) begin
                    state_s = ST_COLLECT;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default:  state_s = ST_COLLECT;
        endcase
    end

    // State, slot storage and registered outputs (outputs decode the next state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_COLLECT;
            phase_r   <= PH_SETUP;
            idx_r     <= 2'd0;
            cnt_r     <= 4'd0;
            k_r       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= 5'd0;
            end
            in_ready  <= 1'b1;
            B1        <= 5'd0;
            B2        <= 5'd0;
            B3        <= 5'd0;
            B4        <= 5'd0;
            Set       <= 1'b0;
            number    <= 2'd0;
            RD_ERR    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bet_count <= 10'd0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;

            if (state_r == ST_COLLECT) begin
                if (cancel) begin
                    k_r <= 2'd0;
                end else if (in_valid) begin
                    slot_r[k_r] <= in_num;
                    k_r         <= k_r + 2'd1;
                end
            end else if ((state_r == ST_DONE) || (state_r == ST_ERROR)) begin
                k_r <= 2'd0;
            end

            // B outputs only change when a checked bet enters DRIVE
            if ((state_r == ST_CHECK) && (state_s == ST_DRIVE)) begin
                B1 <= slot_r[0];
                B2 <= slot_r[1];
                B3 <= slot_r[2];
                B4 <= slot_r[3];
            end

            // number moves at SETUP entry, a full cycle ahead of Set
            if (state_s == ST_DRIVE) begin
                number <= idx_s;
            end

            in_ready <= (state_s == ST_COLLECT);
            Set      <= (state_s == ST_DRIVE) && (phase_s == PH_ASSERT);
            RD_ERR   <= (state_s == ST_ERROR);
            busy     <= (state_s == ST_CHECK) || (state_s == ST_DRIVE) ||
                        (state_s == ST_ERROR);
            done     <= (state_s == ST_DONE);

            if ((state_s == ST_DONE) && (bet_count != 10'd1023)) begin
                bet_count <= bet_count + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_bet_sequencer.sv
module tb_bet_sequencer;

    localparam int G   = 1;
    localparam int H   = 4;
    localparam int DRV = 2 + G;

    localparam int K_SET  = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_RDY  = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic       cancel   = 1'b0;
    logic [4:0] in_num   = 5'd0;
    logic       in_ready;
    logic [4:0] B1, B2, B3, B4;
    logic       Set;
    logic [1:0] number;
    logic       RD_ERR, busy, done;
    logic [9:0] bet_count;

    typedef struct {
        int kind;
        int cyc;
        int num;
        int b1, b2, b3, b4;
        int cnt;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  exp_b[4] = '{0, 0, 0, 0};
    int  exp_count = 0;

    bet_sequencer #(.SET_GAP(G), .ERR_HOLD(H)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_num(in_num),
        .in_ready(in_ready), .cancel(cancel),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .Set(Set), .number(number), .RD_ERR(RD_ERR), .busy(busy),
        .done(done), .bet_count(bet_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int num);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.num  = num;
        e.b1   = exp_b[0];
        e.b2   = exp_b[1];
        e.b3   = exp_b[2];
        e.b4   = exp_b[3];
        e.cnt  = exp_count;
        sb.push_back(e);
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        case (kind)
            K_SET: begin
                chk("number", int'(number), e.num);
                chk("B1", int'(B1), e.b1);
                chk("B2", int'(B2), e.b2);
                chk("B3", int'(B3), e.b3);
                chk("B4", int'(B4), e.b4);
            end
            K_DONE: chk("bet_count_at_done", int'(bet_count), e.cnt);
            K_ERR: begin
                chk("B1_after_err", int'(B1), e.b1);
                chk("B4_after_err", int'(B4), e.b4);
                chk("bet_count_after_err", int'(bet_count), e.cnt);
                chk("busy_in_err", int'(busy), 1);
            end
            K_RDY: begin
                chk("rd_err_at_ready", int'(RD_ERR), 0);
                chk("busy_at_ready", int'(busy), 0);
                chk("bet_count_at_ready", int'(bet_count), e.cnt);
            end
            default: chk("bad_event_kind", kind, 0);
        endcase
    endtask

    // Monitor: pops an expectation whenever the DUT presents an observable event.
    initial begin : monitor
        logic rd_prev, rdy_prev;
        rd_prev  = 1'b0;
        rdy_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_prev  = RD_ERR;
                rdy_prev = in_ready;
            end else begin
                if (Set) check_event(K_SET);
                if (done) check_event(K_DONE);
                if (RD_ERR && !rd_prev) check_event(K_ERR);
                if (in_ready && !rdy_prev) check_event(K_RDY);
                rd_prev  = RD_ERR;
                rdy_prev = in_ready;
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_B1", int'(B1), 0);
        chk("rst_B2", int'(B2), 0);
        chk("rst_B3", int'(B3), 0);
        chk("rst_B4", int'(B4), 0);
        chk("rst_Set", int'(Set), 0);
        chk("rst_number", int'(number), 0);
        chk("rst_RD_ERR", int'(RD_ERR), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bet_count", int'(bet_count), 0);
    endtask

    // Called at posedge+1; returns the edge count of the accepting edge.
    task automatic send_beat(input logic [4:0] v, output int e0);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_num   = v;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        e0       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_bet(input int a, input int b, input int c, input int d,
                            input bit bad);
        int e0;
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) send_beat(5'(v[i]), e0);
        if (bad) begin
            push(K_ERR, e0 + 1, 0);
            push(K_RDY, e0 + 1 + H, 0);
        end else begin
            exp_b = v;
            if (exp_count < 1023) exp_count++;
            for (int i = 0; i < 4; i++) push(K_SET, e0 + 2 + i * DRV, i);
            push(K_DONE, e0 + 1 + 4 * DRV, 0);
            push(K_RDY, e0 + 2 + 4 * DRV, 0);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int e0, guard;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic bet
        send_bet(1, 3, 22, 26, 0);
        // Duplicate bet: rejected, B and count unchanged
        send_bet(21, 22, 23, 21, 1);

        // Two beats then cancel, then a full bet
        send_beat(5'd4, e0);
        send_beat(5'd28, e0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        send_bet(4, 28, 29, 31, 0);

        // cancel together with the 4th beat: stays in COLLECT, k back to 0
        send_beat(5'd5, e0);
        send_beat(5'd6, e0);
        send_beat(5'd7, e0);
        in_valid = 1'b1;
        in_num   = 5'd8;
        cancel   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cancel   = 1'b0;
        chk("cancel4_in_ready", int'(in_ready), 1);
        chk("cancel4_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("cancel4_still_collect", int'(in_ready), 1);
        send_bet(9, 10, 11, 12, 0);

        // Reset in the middle of DRIVE while Set is high for index 2
        send_beat(5'd2, e0);
        send_beat(5'd4, e0);
        send_beat(5'd6, e0);
        send_beat(5'd8, e0);
        exp_b = '{2, 4, 6, 8};
        for (int i = 0; i < 3; i++) push(K_SET, e0 + 2 + i * DRV, i);
        guard = 0;
        while (cyc != e0 + 2 + 2 * DRV && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("reset_point_timeout", 0, 1);
        #1;
        chk("set_before_reset", int'(Set), 1);
        chk("number_before_reset", int'(number), 2);
        reset = 1'b1;
        #1;
        check_reset_vals();
        exp_b     = '{0, 0, 0, 0};
        exp_count = 0;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("sb_empty_after_reset", sb.size(), 0);
        @(posedge clk); #1;
        send_bet(10, 20, 30, 0, 0);

        // Back-to-back bets until bet_count saturates
        for (int i = 0; i < 1025; i++) begin
            send_bet(i % 32, (i + 1) % 32, (i + 2) % 32, (i + 3) % 32, 0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        chk("bet_count_saturated", int'(bet_count), 1023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
